// File: rtl/timer_capture.sv
// Input-capture timer: measures period and high time of an external PWM signal
// in prescaled ticks and pulses o_intCAP once per completed period.
module timer_capture (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [1:0]  i_memAddr,
  input  logic [15:0] i_memDataIn,
  input  logic        i_memWrEn,
  output logic [15:0] o_memDataOut,
  input  logic        i_smIsBooted,
  input  logic        i_smStartPause,
  input  logic        i_pwmIn,
  output logic        o_intCAP
);

  localparam logic [1:0] ADDR_CTRL = 2'b00;
  localparam logic [1:0] ADDR_CNT  = 2'b01;
  localparam logic [1:0] ADDR_PER  = 2'b10;
  localparam logic [1:0] ADDR_HI   = 2'b11;

  logic        syncS1;
  logic        syncS2;
  logic        syncS3;
  logic        en;
  logic [3:0]  pre;
  logic        valid;
  logic        ovf;
  logic        armed;
  logic [3:0]  scale;
  logic [15:0] cnt;
  logic [15:0] per;
  logic [15:0] hi;
  logic [15:0] hiLatch;
  logic        intCap;

  logic        ctrlWr;
  logic        doPause;
  logic        active;
  logic        rise;
  logic        fall;
  logic        actRise;
  logic        actFall;
  logic        tick;
  logic [15:0] cntSat;

  // Register writes are single-cycle strobes; there is no back-pressure, so a
  // write with i_memWrEn high is always accepted on that clock edge.
  assign ctrlWr  = i_memWrEn & (i_memAddr == ADDR_CTRL);
  assign doPause = ~i_smIsBooted | i_smStartPause;
  assign active  = en & ~doPause;
  assign rise    = syncS2 & ~syncS3;
  assign fall    = ~syncS2 & syncS3;
  assign actRise = rise & active;
  assign actFall = fall & active & armed;
  assign tick    = (scale == pre) & active;
  assign cntSat  = (cnt == 16'hFFFF) ? 16'hFFFF : cnt + 16'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      syncS1  <= 1'b0;
      syncS2  <= 1'b0;
      syncS3  <= 1'b0;
      en      <= 1'b0;
      pre     <= 4'd0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
      armed   <= 1'b0;
      scale   <= 4'd0;
      cnt     <= 16'd0;
      per     <= 16'd0;
      hi      <= 16'd0;
      hiLatch <= 16'd0;
      intCap  <= 1'b0;
    end else begin
      // Synchronizer keeps running while paused so resume sees no false edge.
      syncS1 <= i_pwmIn;
      syncS2 <= syncS1;
      syncS3 <= syncS2;
      intCap <= 1'b0;

      if (ctrlWr) begin
        en      <= i_memDataIn[0];
        pre     <= i_memDataIn[7:4];
        valid   <= 1'b0;
        ovf     <= 1'b0;
        armed   <= 1'b0;
        hiLatch <= 16'd0;
        cnt     <= 16'd0;
        scale   <= 4'd0;
      end else begin
        if (tick || actRise || doPause) begin
          scale <= 4'd0;
        end else if (en) begin
          scale <= scale + 4'd1;
        end

        // A tick coinciding with a rise is dropped: the rise restarts the count.
        if (actRise) begin
          cnt <= 16'd0;
        end else if (tick) begin
          if (cnt == 16'hFFFF) begin
            ovf <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // The first rise after enable/resume only arms; the period it opens is
        // the first one that can be measured completely.
        if (doPause) begin
          armed <= 1'b0;
        end else if (actRise) begin
          if (!armed) begin
            armed <= 1'b1;
          end else begin
            per     <= cntSat;
            hi      <= hiLatch;
            hiLatch <= 16'd0;
            valid   <= 1'b1;
            intCap  <= 1'b1;
          end
        end else if (actFall) begin
          hiLatch <= cntSat;
        end
      end
    end
  end

  always_comb begin
    o_memDataOut = 16'd0;
    case (i_memAddr)
      ADDR_CTRL: o_memDataOut = {7'd0, syncS2, pre, armed, ovf, valid, en};
      ADDR_CNT:  o_memDataOut = cnt;
      ADDR_PER:  o_memDataOut = per;
      ADDR_HI:   o_memDataOut = hi;
      default:   o_memDataOut = 16'd0;
    endcase
  end

  assign o_intCAP = intCap;

endmodule

// File: tb/tb_timer_capture.sv
// Bench for timer_capture: register vector tables, square-wave driver with an
// expected-capture queue, and hand-written overflow/pause/reset sequences.
module tb_timer_capture;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [1:0]  i_memAddr;
  logic [15:0] i_memDataIn;
  logic        i_memWrEn;
  logic [15:0] o_memDataOut;
  logic        i_smIsBooted;
  logic        i_smStartPause;
  logic        i_pwmIn;
  logic        o_intCAP;

  timer_capture dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_memAddr      (i_memAddr),
    .i_memDataIn    (i_memDataIn),
    .i_memWrEn      (i_memWrEn),
    .o_memDataOut   (o_memDataOut),
    .i_smIsBooted   (i_smIsBooted),
    .i_smStartPause (i_smStartPause),
    .i_pwmIn        (i_pwmIn),
    .o_intCAP       (o_intCAP)
  );

  // clock / cycle counter
  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // {expected interrupt cycle, PER, HI}
  logic [63:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t rst_vec[4];
  vec_t ign_vec[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic service_int();
    logic [63:0] e;
    logic [1:0]  save_addr;
    if (o_intCAP) begin
      if (exp_q.size() == 0) begin
        check("unexpected_int", 32'(o_intCAP), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("int_cycle", cyc, e[63:32]);
        save_addr = i_memAddr;
        i_memAddr = 2'b10;
        #1 check("per", 32'(o_memDataOut), 32'(e[31:16]));
        i_memAddr = 2'b11;
        #1 check("hi", 32'(o_memDataOut), 32'(e[15:0]));
        i_memAddr = save_addr;
      end
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    service_int();
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [15:0] data);
    i_memAddr   = addr;
    i_memDataIn = data;
    i_memWrEn   = 1'b1;
    step();
    i_memWrEn   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [15:0] exp);
    i_memAddr = addr;
    #1 check(name, 32'(o_memDataOut), 32'(exp));
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    if (v.wr) write_reg(v.addr, v.data);
    else read_check(name, v.addr, v.exp);
  endtask

  task automatic drain(input string name);
    repeat (4) step();
    check(name, exp_q.size(), 32'd0);
  endtask

  // Square wave: rises of periods p >= skip are expected to capture.
  task automatic run_wave(input int n, input int hi_clk, input int per_clk,
                          input logic [15:0] exp_per, input logic [15:0] exp_hi,
                          input logic [3:0] pre, input int skip);
    for (int p = 0; p < n; p++) begin
      if (p >= skip) exp_q.push_back({32'(cyc + 3), exp_per, exp_hi});
      i_pwmIn = 1'b1;
      for (int c = 0; c < per_clk; c++) begin
        if (c == hi_clk) i_pwmIn = 1'b0;
        step();
        if (p >= skip && c == 2)
          read_check("ctrl_high", 2'b00, {7'd0, 1'b1, pre, 4'b1011});
        if (p >= skip && c == per_clk - 1)
          read_check("ctrl_low", 2'b00, {7'd0, 1'b0, pre, 4'b1011});
      end
    end
  endtask

  initial begin
    rst_vec[0] = '{2'b00, 1'b0, 16'h0000, 16'h0000};
    rst_vec[1] = '{2'b01, 1'b0, 16'h0000, 16'h0000};
    rst_vec[2] = '{2'b10, 1'b0, 16'h0000, 16'h0000};
    rst_vec[3] = '{2'b11, 1'b0, 16'h0000, 16'h0000};
    ign_vec[0] = '{2'b01, 1'b1, 16'h1234, 16'h0000};
    ign_vec[1] = '{2'b10, 1'b1, 16'h1234, 16'h0000};
    ign_vec[2] = '{2'b11, 1'b1, 16'h1234, 16'h0000};
    ign_vec[3] = '{2'b10, 1'b0, 16'h0000, 16'h000A};
    ign_vec[4] = '{2'b11, 1'b0, 16'h0000, 16'h0003};
    ign_vec[5] = '{2'b00, 1'b0, 16'h0000, 16'h000B};

    i_rstn         = 1'b0;
    i_memAddr      = 2'b00;
    i_memDataIn    = 16'h0000;
    i_memWrEn      = 1'b0;
    i_smIsBooted   = 1'b1;
    i_smStartPause = 1'b0;
    i_pwmIn        = 1'b0;

    // reset and read-back
    repeat (3) step();
    check("int_in_reset", 32'(o_intCAP), 32'd0);
    i_rstn = 1'b1;
    step();
    foreach (rst_vec[i]) apply_vec(rst_vec[i], "reset_read");

    // disabled: edges are ignored
    run_wave(2, 3, 10, 16'd0, 16'd0, 4'd0, 2);
    drain("sb_disabled");
    read_check("per_disabled", 2'b10, 16'h0000);

    // PRE = 0, period 10, high 3
    write_reg(2'b00, 16'h0001);
    run_wave(4, 3, 10, 16'd10, 16'd3, 4'd0, 1);
    drain("sb_pre0");

    // PRE = 1, period 10, high 4
    write_reg(2'b00, 16'h0011);
    run_wave(4, 4, 10, 16'd5, 16'd2, 4'd1, 1);
    drain("sb_pre1");

    // overflow: arm, hold low past saturation, then capture
    write_reg(2'b00, 16'h0001);
    i_pwmIn = 1'b1;
    repeat (3) step();
    i_pwmIn = 1'b0;
    repeat (70000) step();
    read_check("cnt_sat", 2'b01, 16'hFFFF);
    read_check("ctrl_ovf", 2'b00, 16'h000D);
    exp_q.push_back({32'(cyc + 3), 16'hFFFF, 16'h0003});
    i_pwmIn = 1'b1;
    repeat (3) step();
    i_pwmIn = 1'b0;
    repeat (3) step();
    check("sb_ovf", exp_q.size(), 32'd0);
    read_check("ctrl_ovf_valid", 2'b00, 16'h000F);
    write_reg(2'b00, 16'h0001);
    read_check("ctrl_cleared", 2'b00, 16'h0001);
    read_check("cnt_cleared", 2'b01, 16'h0000);

    // pause spanning two rises, then resume
    run_wave(3, 3, 10, 16'd10, 16'd3, 4'd0, 1);
    i_smStartPause = 1'b1;
    run_wave(2, 3, 10, 16'd0, 16'd0, 4'd0, 2);
    i_smStartPause = 1'b0;
    check("sb_pause", exp_q.size(), 32'd0);
    run_wave(3, 3, 10, 16'd10, 16'd3, 4'd0, 1);
    drain("sb_resume");

    // ignored writes
    foreach (ign_vec[i]) apply_vec(ign_vec[i], "ignored_write");

    // reset lands on the edge that would have raised a capture
    i_pwmIn = 1'b1;
    step();
    step();
    i_rstn = 1'b0;
    step();
    check("int_reset", 32'(o_intCAP), 32'd0);
    foreach (rst_vec[i]) apply_vec(rst_vec[i], "reset_mid");
    i_rstn  = 1'b1;
    i_pwmIn = 1'b0;
    step();
    check("int_after_reset", 32'(o_intCAP), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/timer_capture.md
Name: timer_capture

Overview:
- 16-bit memory-mapped input-capture timer that measures period and high time of an external PWM signal.
- It is the receive-side counterpart of the PWM-generating timer and sits on the same 4-word memory-map slot interface and state inputs.
- It raises a one-cycle capture interrupt per completed period so software can read period and duty.

Parameters:
- none; widths fixed: 16-bit data, 2-bit address, 4-bit prescale.

Ports:
- i_clk  input  1  system clock.
- i_rstn  input  1  synchronous active-low reset.
- i_memAddr  input  2  word select: 00 CTRL, 01 CNT, 10 PER, 11 HI.
- i_memDataIn  input  16  write data.
- i_memWrEn  input  1  write strobe, one cycle.
- o_memDataOut  output  16  combinational read of the addressed register.
- i_smIsBooted  input  1  pause when low.
- i_smStartPause  input  1  pause when high.
- i_pwmIn  input  1  asynchronous PWM input.
- o_intCAP  output  1  registered one-cycle capture pulse.

Behaviour:
- One clock: i_clk. Reset is synchronous and active-low on i_rstn.
- Reset clears all state: EN, PRE, VALID, OVF, ARMED, prescaler, CNT, PER, HI, HILATCH, sync flops, o_intCAP. After reset, o_memDataOut = 0 at every address.
- Input path: 3-flop chain s1 <- i_pwmIn, s2 <- s1, s3 <- s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An input change sampled by s1 at edge N produces its capture/latch register update at edge N+2.
- doPause = ~i_smIsBooted | i_smStartPause.
- Prescaler: 4-bit counter. tick = (scale == PRE) & EN & ~doPause. scale <= 0 on tick, on rise, on CTRL write, or while paused. Otherwise scale increments while EN.
- CNT, priority high to low:
  - CTRL write -> 0.
  - rise (EN & ~doPause) -> 0.
  - tick with CNT == 0xFFFF -> hold at 0xFFFF and set OVF.
  - tick -> CNT+1.
  - otherwise hold.
  - A tick in the same cycle as rise is dropped.
- fall (EN & ~doPause & ARMED): HILATCH <= sat(CNT+1). sat() clamps at 0xFFFF.
- rise (EN & ~doPause):
  - If ~ARMED: set ARMED only; no capture, no interrupt.
  - If ARMED: PER <= sat(CNT+1), HI <= HILATCH, HILATCH <= 0, VALID <= 1, o_intCAP <= 1 on the same edge.
  - o_intCAP is 0 in all other cycles.
- Pause: ARMED is cleared each paused cycle, so measurement restarts after resume. Sync flops keep sampling, so no spurious edge on resume. PER, HI and flags hold.
- CTRL write: EN <= d[0]; PRE <= d[7:4]; clears VALID, OVF, ARMED, HILATCH, CNT and prescaler. PER and HI hold.
- Writes to addresses 01/10/11 are ignored.
- CTRL read: {7'b0, s2, PRE, ARMED, OVF, VALID, EN} (bit8 = s2, bits7:4 = PRE, bit3 = ARMED, bit2 = OVF, bit1 = VALID, bit0 = EN).
- EN = 0: no ticks, no edges acted on, o_intCAP stays 0.
- Units: PER and HI are in ticks of (PRE+1) clocks. With PRE = 0, values equal clock counts. Each captured HI belongs to the period ending at that capture.
- Reset asserted mid-measurement: everything returns to reset values on that edge, including a pending o_intCAP.

Test Plan:
1. Reset, then read all four addresses -> 0x0000 each; o_intCAP = 0 throughout.
2. CTRL = 0x0001. Square wave: period 10 clocks, high 3, four periods.
   - First rise -> ARMED = 1, no interrupt.
   - Each later rise -> PER = 10, HI = 3, o_intCAP high exactly 1 cycle, 2 clocks after s1 samples the rise.
   - CTRL read = 0x010B while the input is high, 0x000B while low.
3. CTRL = 0x0011 (PRE = 1). Period 10, high 4 -> PER = 5, HI = 2 on each capture.
4. CTRL = 0x0001, input held low for 70000 clocks after arming, then a rise.
   - CNT saturates at 0xFFFF; OVF = 1.
   - Capture -> PER = 0xFFFF, o_intCAP pulses.
   - Then write CTRL = 0x0001 -> OVF = 0, VALID = 0, CNT = 0.
5. Running as in scenario 2, assert i_smStartPause for 20 clocks spanning a rise, then release.
   - No interrupt during pause or on the first rise after resume.
   - Second rise after resume -> PER = 10.
6. Write 0x1234 to addresses 01, 10 and 11 mid-run -> values unchanged.
   - Then assert i_rstn low for one cycle -> all registers 0 and o_intCAP = 0 on the next cycle.
